// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/halt sequencer gating the 5-stage pipeline, with drain, pipeline reset and debug readback.
// Optional feature macro: BREAKPOINT_EN adds a fetch-PC breakpoint (bpArm/bpAddr, cause 3).
module pipeline_run_ctrl #(
    parameter int PC_WIDTH     = 8,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmdValid,
    input  logic [1:0]           cmdCode,
    output logic                 cmdReady,
    input  logic                 haltDetected,
    input  logic [PC_WIDTH-1:0]  pcFE,
`ifdef BREAKPOINT_EN
    input  logic                 bpArm,
    input  logic [PC_WIDTH-1:0]  bpAddr,
`endif
    output logic                 pipeEnable,
    output logic                 fetchStall,
    output logic                 pipeReset,
    output logic                 halted,
    output logic                 done,
    output logic [PC_WIDTH-1:0]  haltPC,
    output logic [1:0]           haltCause,
    output logic [CNT_WIDTH-1:0] cycleCount
);
    localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, HALTED = 3'd4, CLEAR = 3'd5;
    localparam logic [1:0] CMD_RUN = 2'd0, CMD_STEP = 2'd1, CMD_HALT = 2'd2, CMD_CLEAR = 2'd3;
    localparam logic [1:0] CAUSE_INSTR = 2'd1, CAUSE_CMD = 2'd2, CAUSE_BP = 2'd3;
    localparam int TW = $clog2(DRAIN_CYCLES + 2);

    logic [2:0]    state, stateNext;
    logic [TW-1:0] timer, timerNext;
    logic [1:0]    causeNext;
    logic          live, accept, bpHit, trigger;

`ifdef BREAKPOINT_EN
    logic runFirst;
    // The first RUN cycle after a resume must not re-hit the breakpoint we stopped on.
    assign bpHit = bpArm && pcFE == bpAddr && !runFirst;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) runFirst <= 1'b0;
        else runFirst <= stateNext == RUN && state != RUN;
    end
`else
    assign bpHit = 1'b0;
`endif

    assign cmdReady   = live && (state == IDLE || state == RUN || state == HALTED);
    assign accept     = cmdValid && cmdReady;
    assign pipeEnable = state == RUN || state == STEP || state == DRAIN;
    assign fetchStall = state == DRAIN;
    assign pipeReset  = state == CLEAR;
    assign halted     = state == HALTED;
    assign trigger    = stateNext == DRAIN && state != DRAIN;

    always_comb begin
        stateNext = state;
        timerNext = timer;
        causeNext = haltCause;
        case (state)
            IDLE, HALTED: begin
                if (accept)
                    stateNext = cmdCode == CMD_RUN   ? RUN   :
                                cmdCode == CMD_STEP  ? STEP  :
                                cmdCode == CMD_CLEAR ? CLEAR : state;
            end
            RUN: begin
                if (accept && cmdCode == CMD_CLEAR) stateNext = CLEAR;
                else if (haltDetected) begin
                    stateNext = DRAIN;
                    causeNext = CAUSE_INSTR;
                end else if (bpHit) begin
                    stateNext = DRAIN;
                    causeNext = CAUSE_BP;
                end else if (accept && cmdCode == CMD_HALT) begin
                    stateNext = DRAIN;
                    causeNext = CAUSE_CMD;
                end
            end
            STEP: begin
                stateNext = haltDetected ? DRAIN : HALTED;
                causeNext = haltDetected ? CAUSE_INSTR : haltCause;
            end
            DRAIN: begin
                stateNext = timer == '0 ? HALTED : DRAIN;
                timerNext = timer - TW'(1);
            end
            CLEAR: begin
                stateNext = timer == '0 ? IDLE : CLEAR;
                timerNext = timer - TW'(1);
            end
            default: stateNext = IDLE;
        endcase
        // The shared down-counter is loaded on entry so DRAIN/CLEAR last DRAIN_CYCLES/2 cycles.
        if (trigger) timerNext = TW'(DRAIN_CYCLES - 1);
        if (stateNext == CLEAR && state != CLEAR) timerNext = TW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            live       <= 1'b0;
            done       <= 1'b0;
            haltPC     <= '0;
            haltCause  <= '0;
            cycleCount <= '0;
        end else begin
            state <= stateNext;
            timer <= timerNext;
            live  <= 1'b1;
            done  <= stateNext == HALTED && state != HALTED;
            if (state == CLEAR) begin
                haltPC     <= '0;
                haltCause  <= '0;
                cycleCount <= '0;
            end else begin
                if (trigger) begin
                    haltPC    <= pcFE;
                    haltCause <= causeNext;
                end
                if (pipeEnable && cycleCount != '1) cycleCount <= cycleCount + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: directed self-checking bench; narrow counter so saturation is reachable.
module tb_pipeline_run_ctrl;
    localparam int PW = 8;
    localparam int CW = 5;
    localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_HALT = 2'd2, C_CLEAR = 2'd3;

    logic          clock = 1'b0, reset = 1'b0, cmdValid = 1'b0, haltDetected = 1'b0;
    logic [1:0]    cmdCode = 2'd0;
    logic [PW-1:0] pcFE = '0;
    logic          cmdReady, pipeEnable, fetchStall, pipeReset, halted, done;
    logic [PW-1:0] haltPC;
    logic [1:0]    haltCause;
    logic [CW-1:0] cycleCount;
`ifdef BREAKPOINT_EN
    logic          bpArm = 1'b0;
    logic [PW-1:0] bpAddr = '0;
`endif
    int errors = 0, checks = 0, stall, dsum;
    logic [5:0] rdy, pe, dn;

    pipeline_run_ctrl #(.PC_WIDTH(PW), .DRAIN_CYCLES(4), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdCode(cmdCode), .cmdReady(cmdReady),
        .haltDetected(haltDetected), .pcFE(pcFE),
`ifdef BREAKPOINT_EN
        .bpArm(bpArm), .bpAddr(bpAddr),
`endif
        .pipeEnable(pipeEnable), .fetchStall(fetchStall), .pipeReset(pipeReset), .halted(halted),
        .done(done), .haltPC(haltPC), .haltCause(haltCause), .cycleCount(cycleCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic cmd(input logic [1:0] c);
        cmdValid = 1'b1;
        cmdCode  = c;
        tick();
        cmdValid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_pe", pipeEnable, 0);
        check("rst_ready", cmdReady, 0);
        check("rst_halted", halted, 0);
        check("rst_done", done, 0);
        check("rst_count", cycleCount, 0);
        reset = 1'b1;
        tick();
        check("ready_after_rst", cmdReady, 1);
        check("idle_pe", pipeEnable, 0);
        // HALT command after 10 run cycles
        pcFE = 8'h33;
        cmd(C_RUN);
        check("run_pe", pipeEnable, 1);
        repeat (9) tick();
        cmd(C_HALT);
        check("drain_stall", fetchStall, 1);
        check("drain_count", cycleCount, 10);
        check("halt_pc_cmd", haltPC, 8'h33);
        check("cause_cmd", haltCause, 2);
        stall = 0;
        repeat (4) begin
            stall += fetchStall;
            tick();
        end
        check("stall_cycles", stall, 4);
        check("halted1", halted, 1);
        check("done1", done, 1);
        check("count14", cycleCount, 14);
        check("halted_pe", pipeEnable, 0);
        tick();
        check("done_pulse", done, 0);
        cmd(C_HALT);
        check("halt_ignored", halted, 1);
        check("halted_ready", cmdReady, 1);
        // CLEAR from HALTED
        cmd(C_CLEAR);
        check("clr_reset1", pipeReset, 1);
        check("clr_pe", pipeEnable, 0);
        check("clr_ready", cmdReady, 0);
        tick();
        check("clr_reset2", pipeReset, 1);
        tick();
        check("clr_done", pipeReset, 0);
        check("clr_count", cycleCount, 0);
        check("clr_cause", haltCause, 0);
        check("clr_pc", haltPC, 0);
        check("clr_idle_ready", cmdReady, 1);
        check("clr_idle_halted", halted, 0);
        // three back-to-back STEPs with cmdValid held
        cmdValid = 1'b1;
        cmdCode  = C_STEP;
        for (int i = 0; i < 6; i++) begin
            tick();
            rdy = {rdy[4:0], cmdReady};
            pe  = {pe[4:0], pipeEnable};
            dn  = {dn[4:0], done};
        end
        cmdValid = 1'b0;
        check("step_ready", rdy, 6'b010101);
        check("step_pe", pe, 6'b101010);
        check("step_done", dn, 6'b010101);
        check("step_count", cycleCount, 3);
        check("step_halted", halted, 1);
        // HALT instruction and HALT command in the same cycle
        pcFE = 8'h1C;
        cmd(C_RUN);
        haltDetected = 1'b1;
        cmd(C_HALT);
        haltDetected = 1'b0;
        check("prio_stall", fetchStall, 1);
        check("prio_cause", haltCause, 1);
        check("prio_pc", haltPC, 8'h1C);
        repeat (4) tick();
        check("prio_halted", halted, 1);
        check("prio_count", cycleCount, 8);
        // HALT instruction seen during a STEP
        cmd(C_STEP);
        haltDetected = 1'b1;
        pcFE = 8'h2A;
        tick();
        haltDetected = 1'b0;
        check("stepdrain_stall", fetchStall, 1);
        check("stepdrain_pc", haltPC, 8'h2A);
        check("stepdrain_cause", haltCause, 1);
        repeat (4) tick();
        check("stepdrain_halted", halted, 1);
        // reset in the middle of a drain
        cmd(C_RUN);
        cmd(C_HALT);
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_pe", pipeEnable, 0);
        check("abort_stall", fetchStall, 0);
        check("abort_ready", cmdReady, 0);
        check("abort_cause", haltCause, 0);
        check("abort_count", cycleCount, 0);
        tick();
        reset = 1'b1;
        dsum = 0;
        repeat (6) begin
            tick();
            dsum += done;
        end
        check("abort_no_done", dsum, 0);
        check("abort_idle_halted", halted, 0);
        check("abort_idle_pe", pipeEnable, 0);
        check("abort_idle_ready", cmdReady, 1);
        // counter saturation; RUN while running is ignored
        cmd(C_RUN);
        cmd(C_RUN);
        check("rerun_pe", pipeEnable, 1);
        check("rerun_stall", fetchStall, 0);
        repeat (40) tick();
        check("sat_count", cycleCount, 31);
        cmd(C_HALT);
        repeat (4) tick();
        check("sat_hold", cycleCount, 31);
        check("sat_halted", halted, 1);
`ifdef BREAKPOINT_EN
        cmd(C_CLEAR);
        repeat (2) tick();
        bpArm  = 1'b1;
        bpAddr = 8'h08;
        pcFE   = 8'h00;
        cmd(C_RUN);
        tick();
        pcFE = 8'h04;
        tick();
        pcFE = 8'h08;
        tick();
        check("bp_stall", fetchStall, 1);
        check("bp_cause", haltCause, 3);
        check("bp_pc", haltPC, 8'h08);
        repeat (4) tick();
        check("bp_halted", halted, 1);
        cmd(C_RUN);
        check("bp_resume_pe", pipeEnable, 1);
        pcFE = 8'h0C;
        tick();
        check("bp_resume_stall", fetchStall, 0);
        check("bp_resume_run", pipeEnable, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
